// File: rtl/interrupt_vector_sequencer.sv
// Interrupt/reset vector sequencer: synchronises resb/irqb/nmib, runs the post-reset
// sequence and arbitrates NMI/IRQ at instruction boundaries into a valid/ack vector request.
module interrupt_vector_sequencer #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned RESET_CYCLES = 7,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       fclk,
    input  logic       resb,
    input  logic       irqb,
    input  logic       nmib,
    input  logic       i_flag,
    input  logic       sync,
    input  logic       rdy,
    input  logic       wai_active,
    input  logic       vec_ack,
    output logic [4:0] vector_operations,
    output logic       vec_valid,
    output logic       int_take,
    output logic       wake,
    output logic       set_i,
    output logic       clr_d,
    output logic       b_clear
);

    typedef enum logic [2:0] {
        StRstHold,
        StRstReq,
        StRstStack,
        StRun,
        StVecReq
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(RESET_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] irq_sync_q, nmi_sync_q;
    logic                   nmi_prev_q;
    logic                   nmi_pending_q, nmi_pending_d;
    logic                   src_nmi_q, src_nmi_d;
    logic                   pulse_q, pulse_d;
    logic                   woke_q, woke_d;

    logic irq_sync, nmi_sync, nmi_edge, irq_active;

    assign irq_sync   = irq_sync_q[SYNC_STAGES-1];
    assign nmi_sync   = nmi_sync_q[SYNC_STAGES-1];
    assign nmi_edge   = nmi_prev_q & ~nmi_sync;
    assign irq_active = ~irq_sync & ~i_flag;

    assign set_i = pulse_q;
    assign clr_d = pulse_q;

    // Synchronisers and the NMI edge history keep running regardless of rdy.
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            irq_sync_q <= '1;
            nmi_sync_q <= '1;
            nmi_prev_q <= 1'b1;
        end else begin
            irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irqb};
            nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nmib};
            nmi_prev_q <= nmi_sync;
        end
    end

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            state_q       <= StRstHold;
            cnt_q         <= '0;
            nmi_pending_q <= 1'b0;
            src_nmi_q     <= 1'b0;
            pulse_q       <= 1'b0;
            woke_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nmi_pending_q <= nmi_pending_d;
            src_nmi_q     <= src_nmi_d;
            pulse_q       <= pulse_d;
            woke_q        <= woke_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        src_nmi_d         = src_nmi_q;
        pulse_d           = 1'b0;
        woke_d            = woke_q;
        nmi_pending_d     = nmi_pending_q;
        vector_operations = 5'b00000;
        vec_valid         = 1'b0;
        b_clear           = 1'b0;
        int_take          = 1'b0;
        wake              = 1'b0;

        unique case (state_q)
            StRstHold: begin
                if (rdy) begin
                    if (cnt_q == CntLast) begin
                        state_d = StRstReq;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRstReq: begin
                vector_operations = 5'b11000;
                vec_valid         = 1'b1;
                if (rdy && vec_ack) state_d = StRstStack;
            end
            StRstStack: begin
                vector_operations = 5'b00001;
                vec_valid         = 1'b1;
                if (rdy) begin
                    state_d = StRun;
                    pulse_d = 1'b1;
                end
            end
            StRun: begin
                if (rdy && sync && (nmi_pending_q || irq_active)) begin
                    int_take  = 1'b1;
                    src_nmi_d = nmi_pending_q;
                    state_d   = StVecReq;
                end
                // WAI release ignores the I flag; vectoring still obeys it.
                if (rdy && wai_active && !woke_q && (!irq_sync || nmi_pending_q)) wake = 1'b1;
            end
            StVecReq: begin
                vector_operations = src_nmi_q ? 5'b10100 : 5'b10010;
                vec_valid         = 1'b1;
                b_clear           = 1'b1;
                if (rdy && vec_ack) begin
                    state_d = StRun;
                    pulse_d = 1'b1;
                end
            end
            default: state_d = StRstHold;
        endcase

        if (wake) begin
            woke_d = 1'b1;
        end else if (!wai_active) begin
            woke_d = 1'b0;
        end

        // A fresh edge on the ack cycle wins over the clear so it is not lost.
        if (state_q == StRstHold) begin
            nmi_pending_d = 1'b0;
        end else if (nmi_edge) begin
            nmi_pending_d = 1'b1;
        end else if (state_q == StVecReq && src_nmi_q && rdy && vec_ack) begin
            nmi_pending_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_interrupt_vector_sequencer.sv
// Bench for interrupt_vector_sequencer: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural timeline model.
module tb_interrupt_vector_sequencer;

    localparam int S  = 2;
    localparam int RC = 7;

    localparam int PDead   = 0;
    localparam int PRstVec = 1;
    localparam int PRstStk = 2;
    localparam int PRun    = 3;
    localparam int PVec    = 4;

    logic       fclk = 1'b0;
    logic       resb, irqb, nmib, i_flag, sync, rdy, wai_active, vec_ack;
    logic [4:0] vector_operations;
    logic       vec_valid, int_take, wake, set_i, clr_d, b_clear;

    always #5 fclk = ~fclk;

    interrupt_vector_sequencer #(
        .SYNC_STAGES (S),
        .RESET_CYCLES(RC),
        .CNT_W       (4)
    ) dut (
        .fclk             (fclk),
        .resb             (resb),
        .irqb             (irqb),
        .nmib             (nmib),
        .i_flag           (i_flag),
        .sync             (sync),
        .rdy              (rdy),
        .wai_active       (wai_active),
        .vec_ack          (vec_ack),
        .vector_operations(vector_operations),
        .vec_valid        (vec_valid),
        .int_take         (int_take),
        .wake             (wake),
        .set_i            (set_i),
        .clr_d            (clr_d),
        .b_clear          (b_clear)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: where the block is in its timeline, plus pin sample histories.
    int   phase;
    int   dead_left;
    logic pending, kind_nmi, pulse, wake_given;
    logic pin_n [0:S];
    logic pin_i [0:S];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        phase      = PDead;
        dead_left  = RC;
        pending    = 1'b0;
        kind_nmi   = 1'b0;
        pulse      = 1'b0;
        wake_given = 1'b0;
        for (int k = 0; k <= S; k++) begin
            pin_n[k] = 1'b1;
            pin_i[k] = 1'b1;
        end
    endtask

    // {ops[4:0], valid, int_take, wake, set_i, clr_d, b_clear}
    function automatic logic [10:0] expect_out();
        logic [4:0] ops;
        logic       valid, it, wk, bc, irq_low;
        ops     = 5'b0;
        valid   = 1'b0;
        it      = 1'b0;
        wk      = 1'b0;
        bc      = 1'b0;
        irq_low = !pin_i[S-1];
        case (phase)
            PRstVec: begin ops = 5'b11000; valid = 1'b1; end
            PRstStk: begin ops = 5'b00001; valid = 1'b1; end
            PRun: begin
                it = rdy && sync && (pending || (irq_low && !i_flag));
                wk = rdy && wai_active && !wake_given && (irq_low || pending);
            end
            PVec: begin
                ops   = kind_nmi ? 5'b10100 : 5'b10010;
                valid = 1'b1;
                bc    = 1'b1;
            end
            default: ;
        endcase
        return {ops, valid, it, wk, pulse, pulse, bc};
    endfunction

    task automatic model_edge();
        logic [10:0] e;
        logic        nmi_fell, ack_ok, new_pending;
        if (!resb) begin
            model_reset();
            return;
        end
        e        = expect_out();
        nmi_fell = pin_n[S] && !pin_n[S-1];
        ack_ok   = rdy && vec_ack;
        new_pending = pending;
        if (phase == PDead) new_pending = 1'b0;
        else if (nmi_fell) new_pending = 1'b1;
        else if (phase == PVec && kind_nmi && ack_ok) new_pending = 1'b0;
        pulse = 1'b0;
        case (phase)
            PDead: if (rdy) begin
                if (dead_left == 1) phase = PRstVec;
                else dead_left--;
            end
            PRstVec: if (ack_ok) phase = PRstStk;
            PRstStk: if (rdy) begin phase = PRun; pulse = 1'b1; end
            PRun: if (e[4]) begin phase = PVec; kind_nmi = pending; end
            PVec: if (ack_ok) begin phase = PRun; pulse = 1'b1; end
            default: ;
        endcase
        if (e[3]) wake_given = 1'b1;
        else if (!wai_active) wake_given = 1'b0;
        pending = new_pending;
        for (int k = S; k > 0; k--) begin
            pin_n[k] = pin_n[k-1];
            pin_i[k] = pin_i[k-1];
        end
        pin_n[0] = nmib;
        pin_i[0] = irqb;
    endtask

    // Inputs are set by the caller shortly after a posedge; compare, then advance one edge.
    task automatic cyc();
        #1;
        if (!resb) model_reset();
        chk("cycle_outputs",
            {21'b0, vector_operations, vec_valid, int_take, wake, set_i, clr_d, b_clear},
            {21'b0, expect_out()});
        @(posedge fclk);
        model_edge();
        #1;
    endtask

    task automatic wait_reset_vector(input string name);
        int n;
        n = 0;
        while (!vec_valid && n < 20) begin
            cyc();
            n++;
        end
        chk(name, n, RC);
    endtask

    initial begin
        int w_cnt, t_cnt;
        resb = 1'b0; irqb = 1'b1; nmib = 1'b1; i_flag = 1'b0;
        sync = 1'b0; rdy = 1'b1; wai_active = 1'b0; vec_ack = 1'b0;
        model_reset();
        repeat (3) cyc();
        #1;
        chk("reset_ops", vector_operations, 5'b00000);
        chk("reset_valid", vec_valid, 1'b0);

        // Post-reset sequence
        resb = 1'b1;
        wait_reset_vector("dead_time");
        chk("rst_vec_ops", vector_operations, 5'b11000);
        chk("rst_vec_bclr", b_clear, 1'b0);
        cyc();
        vec_ack = 1'b1; cyc(); vec_ack = 1'b0;
        #1;
        chk("rst_stack_ops", vector_operations, 5'b00001);
        chk("rst_stack_valid", vec_valid, 1'b1);
        cyc();
        #1;
        chk("rst_set_i", set_i, 1'b1);
        chk("rst_clr_d", clr_d, 1'b1);
        chk("rst_run_valid", vec_valid, 1'b0);
        cyc();
        #1;
        chk("rst_set_i_once", set_i, 1'b0);

        // IRQ with I clear; deassert after int_take must not cancel
        irqb = 1'b0;
        repeat (3) cyc();
        sync = 1'b1;
        #1 chk("irq_take", int_take, 1'b1);
        cyc();
        sync = 1'b0;
        #1;
        chk("irq_ops", vector_operations, 5'b10010);
        chk("irq_bclr", b_clear, 1'b1);
        repeat (2) cyc();
        irqb = 1'b1;
        #1 chk("irq_hold_ops", vector_operations, 5'b10010);
        vec_ack = 1'b1; cyc(); vec_ack = 1'b0;
        #1;
        chk("irq_ack_valid", vec_valid, 1'b0);
        chk("irq_ack_set_i", set_i, 1'b1);
        repeat (3) cyc();

        // IRQ masked by I
        i_flag = 1'b1; irqb = 1'b0;
        repeat (3) cyc();
        sync = 1'b1;
        #1 chk("irq_masked", int_take, 1'b0);
        repeat (2) cyc();
        sync = 1'b0; irqb = 1'b1; i_flag = 1'b0;
        repeat (3) cyc();

        // NMI and IRQ together: NMI first, then IRQ
        nmib = 1'b0; irqb = 1'b0;
        repeat (4) cyc();
        sync = 1'b1;
        #1 chk("nmi_take", int_take, 1'b1);
        cyc();
        sync = 1'b0;
        #1 chk("nmi_first_ops", vector_operations, 5'b10100);
        vec_ack = 1'b1; cyc(); vec_ack = 1'b0;
        sync = 1'b1;
        #1 chk("irq_second_take", int_take, 1'b1);
        cyc();
        sync = 1'b0;
        #1 chk("irq_second_ops", vector_operations, 5'b10010);
        vec_ack = 1'b1; cyc(); vec_ack = 1'b0;
        irqb = 1'b1;
        repeat (3) cyc();
        sync = 1'b1;
        #1 chk("nmi_held_no_retrigger", int_take, 1'b0);
        repeat (2) cyc();
        sync = 1'b0;

        // New NMI edge on the ack cycle keeps NMI pending
        nmib = 1'b1; repeat (4) cyc();
        nmib = 1'b0; repeat (4) cyc();
        sync = 1'b1;
        #1 chk("nmi2_take", int_take, 1'b1);
        cyc();
        sync = 1'b0; nmib = 1'b1;
        repeat (3) cyc();
        nmib = 1'b0;
        repeat (S) cyc();
        vec_ack = 1'b1; cyc(); vec_ack = 1'b0;
        sync = 1'b1;
        #1 chk("nmi_reedge_take", int_take, 1'b1);
        cyc();
        sync = 1'b0;
        #1 chk("nmi_reedge_ops", vector_operations, 5'b10100);
        vec_ack = 1'b1; cyc(); vec_ack = 1'b0;
        nmib = 1'b1;
        repeat (3) cyc();

        // WAI release with I set: one wake, no vector
        i_flag = 1'b1; wai_active = 1'b1; irqb = 1'b0; sync = 1'b1;
        w_cnt = 0; t_cnt = 0;
        repeat (8) begin
            cyc();
            #1;
            if (wake) w_cnt++;
            if (int_take) t_cnt++;
        end
        chk("wai_wake_count", w_cnt, 1);
        chk("wai_no_vector", t_cnt, 0);
        wai_active = 1'b0; irqb = 1'b1; sync = 1'b0; i_flag = 1'b0;
        repeat (3) cyc();

        // Reset while a vector is outstanding
        irqb = 1'b0;
        repeat (3) cyc();
        sync = 1'b1; cyc(); sync = 1'b0;
        #1 chk("pre_abort_valid", vec_valid, 1'b1);
        resb = 1'b0;
        #1 chk("abort_outputs",
               {vector_operations, vec_valid, int_take, wake, set_i, clr_d, b_clear}, 11'b0);
        cyc();
        resb = 1'b1; irqb = 1'b1;
        wait_reset_vector("dead_time_again");

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            resb       = ($urandom_range(0, 199) != 0);
            rdy        = ($urandom_range(0, 7) != 0);
            sync       = ($urandom_range(0, 2) == 0);
            vec_ack    = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) i_flag = ~i_flag;
            if ($urandom_range(0, 19) == 0) irqb = ~irqb;
            if ($urandom_range(0, 9) == 0) nmib = ~nmib;
            if ($urandom_range(0, 15) == 0) wai_active = ~wai_active;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
